buffer_lane_dma: RTL and testbench

Byte-lane transfer engine for one bus port (bus0..bus3) of the dual-ported PLB staging buffer. On command it either streams a block of bytes out of the lane into a valid/ready consumer (read mode), or writes a block of bytes from a valid/ready producer into the lane (write mode). One instance sits in front of each lane. It is the only driver of that lane's bus-side address, data and write-enable.

---
 rtl/buffer_lane_dma.sv | 121 ++++++++++++
 tb/tb_buffer_lane_dma.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_lane_dma.sv
// Byte-lane DMA engine: streams a block out of one staging-buffer lane (read)
// or writes a streamed block into it (write), owning the lane's bus-side port.
module buffer_lane_dma (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [13:0] cmd_addr,
    input  logic [14:0] cmd_len,
    output logic        busy,
    output logic        done,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        m_ready,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [13:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    input  logic [7:0]  bus_rdata
);

    localparam int unsigned AW = 14;
    localparam int unsigned LW = 15;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_CAP  = 3'd2,
        S_WR      = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_rem;
    logic            r_m_valid;
    logic            r_m_last;
    logic [DW-1:0]   r_m_data;

    logic            w_capture;
    logic            w_out_take;
    logic            w_wr_hs;

    // Capture only while bytes remain; once remaining hits zero the last byte waits for its handshake.
    assign w_capture  = (r_state == S_RD_CAP) && (r_rem != LW'(0)) && (!r_m_valid || m_ready);
    assign w_out_take = r_m_valid && m_ready;
    assign w_wr_hs    = (r_state == S_WR) && s_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr <= cmd_addr;
                        r_rem  <= cmd_len;
                        if (cmd_len == LW'(0))
                            r_state <= S_FIN;
                        else if (cmd_write)
                            r_state <= S_WR;
                        else
                            r_state <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: r_state <= S_RD_CAP;
                S_RD_CAP: begin
                    if (w_capture) begin
                        r_addr  <= r_addr + AW'(1);
                        r_rem   <= r_rem - LW'(1);
                        r_state <= (r_rem == LW'(1)) ? S_RD_CAP : S_RD_ADDR;
                    end else if ((r_rem == LW'(0)) && w_out_take && r_m_last) begin
                        r_state <= S_FIN;
                    end
                end
                S_WR: begin
                    if (s_valid) begin
                        r_addr <= r_addr + AW'(1);
                        r_rem  <= r_rem - LW'(1);
                        if (r_rem == LW'(1))
                            r_state <= S_FIN;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Output byte register: a new capture may replace a byte drained this cycle.
            if (w_capture) begin
                r_m_valid <= 1'b1;
                r_m_data  <= bus_rdata;
                r_m_last  <= (r_rem == LW'(1));
            end else if (w_out_take) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign s_ready   = (r_state == S_WR);
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_last    = r_m_last;
    assign bus_addr  = r_addr;
    assign bus_we    = w_wr_hs;
    assign bus_wdata = w_wr_hs ? s_data : DW'(0);

endmodule

// File: tb/tb_buffer_lane_dma.sv
// Bench for buffer_lane_dma: lane memory stand-in, byte-array reference of the lane,
// vector table of directed commands, a reset-abort sequence and random commands.
module tb_buffer_lane_dma;

    localparam int LANE = 16384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [13:0] cmd_addr;
    logic [14:0] cmd_len;
    logic        busy, done;
    logic        m_valid, m_last, m_ready;
    logic [7:0]  m_data;
    logic        s_valid, s_ready;
    logic [7:0]  s_data;
    logic [13:0] bus_addr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic        bus_we;

    buffer_lane_dma dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Lane stand-in: write at the edge, read data one cycle after the address.
    logic [7:0] lane [LANE];
    always @(posedge clk) begin
        if (bus_we) lane[bus_addr] <= bus_wdata;
        bus_rdata <= lane[bus_addr];
    end

    logic [7:0] ref_mem [LANE];
    logic [7:0] wbytes  [LANE];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_m_last",    32'(m_last),    32'd0);
        chk("rst_s_ready",   32'(s_ready),   32'd0);
        chk("rst_bus_we",    32'(bus_we),    32'd0);
        chk("rst_bus_addr",  32'(bus_addr),  32'd0);
        chk("rst_m_data",    32'(m_data),    32'd0);
        chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    endtask

    // One command end to end; mode 0 = full-rate streams, 1 = random, 2 = 5-cycle stall after first byte.
    task automatic run_cmd(input bit wr, input int addr, input int len, input int pat,
                           input int mode, input int lat);
        int C, t, widx, nhs, nwe, nmv, done_cyc, stall, last_hs, last_we;
        bit seen, pv, pr, pl, exp_we;
        logic [7:0] pd;
        widx = 0; nhs = 0; nwe = 0; nmv = 0; done_cyc = -1; stall = 0;
        last_hs = -1; last_we = -1; seen = 0; pv = 0; pr = 0; pl = 0; pd = 8'd0;
        for (int i = 0; i < len; i++)
            wbytes[i] = (pat == 1) ? 8'(170 + 17 * i) : 8'($urandom);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = 14'(addr); cmd_len = 15'(len);
        s_valid = 1'b0; m_ready = 1'b1;
        #1;
        chk("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
        C = cyc;

        for (int k = 0; k < 8 * len + 60 && done_cyc < 0; k++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = 14'($urandom);
            cmd_len   = 15'($urandom);
            if (mode == 0) m_ready = 1'b1;
            else if (mode == 1) m_ready = 1'($urandom_range(0, 1));
            else begin
                if (m_valid && !seen) begin seen = 1; stall = 5; end
                m_ready = (stall == 0);
                if (stall > 0) stall--;
            end
            s_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            s_data  = (widx < len) ? wbytes[widx] : 8'($urandom);
            #1;
            t = cyc - C;

            chk("busy_during_cmd", 32'(busy), 32'd1);
            chk("cmd_ready_during_cmd", 32'(cmd_ready), 32'd0);
            chk("s_ready", 32'(s_ready), 32'(wr && t >= 1 && widx < len));
            exp_we = wr && s_valid && t >= 1 && widx < len;
            chk("bus_we", 32'(bus_we), 32'(exp_we));
            if (bus_we) nwe++;
            if (exp_we) begin
                chk("wr_addr", 32'(bus_addr), 32'((addr + widx) % LANE));
                chk("wr_data", 32'(bus_wdata), 32'(wbytes[widx]));
                if (mode == 0) chk("wr_timing", 32'(t), 32'(1 + widx));
                last_we = t;
                widx++;
            end
            if (!wr && len > 0 && (t == 1 || t == 2))
                chk("rd_base_addr", 32'(bus_addr), 32'(addr));
            if (pv && !pr) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data",  32'(m_data),  32'(pd));
                chk("hold_last",  32'(m_last),  32'(pl));
            end
            if (mode == 2 && m_valid && !m_ready && nhs == 0)
                chk("stall_addr", 32'(bus_addr), 32'((addr + 1) % LANE));
            if (m_valid) nmv++;
            if (m_valid && m_ready && !wr && nhs < len) begin
                chk("rd_data", 32'(m_data), 32'(ref_mem[(addr + nhs) % LANE]));
                chk("rd_last", 32'(m_last), 32'(nhs == len - 1));
                if (mode == 0) chk("rd_timing", 32'(t), 32'(3 + 2 * nhs));
                if (mode == 2 && nhs == 1) chk("stall_resume", 32'(t), 32'd9);
                last_hs = t;
                nhs++;
            end
            if (done) done_cyc = t;
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end
        cmd_valid = 1'b0;
        s_valid   = 1'b0;

        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        if (lat >= 0) chk("done_latency", 32'(done_cyc), 32'(lat));
        if (wr) begin
            chk("write_count", 32'(nwe), 32'(len));
            chk("m_valid_in_write", 32'(nmv), 32'd0);
            if (len > 0) chk("done_after_write", 32'(done_cyc), 32'(last_we + 1));
            for (int i = 0; i < len; i++) ref_mem[(addr + i) % LANE] = wbytes[i];
        end else begin
            chk("we_in_read", 32'(nwe), 32'd0);
            chk("read_count", 32'(nhs), 32'(len));
            if (len > 0) chk("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
            else chk("m_valid_len0", 32'(nmv), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("ready_after_done", 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        bit wr;
        int addr;
        int len;
        int pat;
        int mode;
        int lat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int C, rlen, rmode, raddr;
        bit rwr;
        vecs[0]  = '{1'b1, 'h0005,     4, 1, 0,     5};
        vecs[1]  = '{1'b0, 'h0005,     4, 0, 0,    10};
        vecs[2]  = '{1'b0, 'h0005,     4, 0, 2,    14};
        vecs[3]  = '{1'b1, 'h3FFE,     4, 1, 0,     5};
        vecs[4]  = '{1'b0, 'h3FFE,     4, 0, 0,    10};
        vecs[5]  = '{1'b1, 'h0100,     0, 0, 0,     1};
        vecs[6]  = '{1'b0, 'h0200,     0, 0, 0,     1};
        vecs[7]  = '{1'b1, 'h0010,     1, 0, 0,     2};
        vecs[8]  = '{1'b0, 'h0010,     1, 0, 0,     4};
        vecs[9]  = '{1'b1, 'h1234,    20, 0, 1,    -1};
        vecs[10] = '{1'b0, 'h1234,    20, 0, 1,    -1};
        vecs[11] = '{1'b0, 'h3FF0,    40, 0, 1,    -1};
        vecs[12] = '{1'b1, 'h2000, 16384, 0, 0, 16385};
        vecs[13] = '{1'b0, 'h1FE0,    64, 0, 0,   130};

        for (int i = 0; i < LANE; i++) begin
            lane[i]    = 8'($urandom);
            ref_mem[i] = lane[i];
        end
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        m_ready = 1'b0; s_valid = 1'b0; s_data = '0;
        #3;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++)
            run_cmd(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].pat, vecs[v].mode, vecs[v].lat);

        // Reset during a 6-byte write after two bytes have been committed.
        for (int i = 0; i < 6; i++) wbytes[i] = 8'($urandom);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 14'h0800; cmd_len = 15'd6;
        s_valid = 1'b1; s_data = wbytes[0];
        #1;
        C = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; s_data = wbytes[0];
        #1;
        chk("rstseq_we0", 32'(bus_we), 32'd1);
        chk("rstseq_addr0", 32'(bus_addr), 32'h800);
        chk("rstseq_cycle", 32'(cyc - C), 32'd1);
        @(negedge clk);
        s_data = wbytes[1];
        #1;
        chk("rstseq_we1", 32'(bus_we), 32'd1);
        chk("rstseq_addr1", 32'(bus_addr), 32'h801);
        @(negedge clk);
        s_data = wbytes[2];
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem[14'h800] = wbytes[0];
        ref_mem[14'h801] = wbytes[1];
        run_cmd(1'b0, 'h0800, 6, 0, 0, 14);

        for (int r = 0; r < 30; r++) begin
            rwr   = 1'($urandom_range(0, 1));
            raddr = int'($urandom_range(0, LANE - 1));
            rlen  = int'($urandom_range(0, 64));
            rmode = int'($urandom_range(0, 1));
            run_cmd(rwr, raddr, rlen, 0, rmode,
                    (rmode != 0) ? -1 : (rlen == 0) ? 1 : rwr ? rlen + 1 : 2 * rlen + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
